// File: rtl/alu_shift_pipe.sv
// alu_shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROL/ROR) with a valid/ready handshake.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   in_valid_i / in_ready_o / op_i / data_i / amt_i / tag_i   request side
//   out_valid_o / out_ready_i / result_o / tag_o / illegal_o  result side
module alu_shift_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_STAGES = 2,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          in_valid_i,
   output logic                          in_ready_o,
   input  logic [2:0]                    op_i,
   input  logic [DATA_WIDTH-1:0]         data_i,
   input  logic [$clog2(DATA_WIDTH)-1:0] amt_i,
   input  logic [TAG_WIDTH-1:0]          tag_i,
   output logic                          out_valid_o,
   input  logic                          out_ready_i,
   output logic [DATA_WIDTH-1:0]         result_o,
   output logic [TAG_WIDTH-1:0]          tag_o,
   output logic                          illegal_o
);

   localparam int DW  = DATA_WIDTH;
   localparam int NS  = NUM_STAGES;
   localparam int AW  = $clog2(DATA_WIDTH);
   // mux levels per stage; the last stage may get fewer (or none)
   localparam int LPS = (AW + NS - 1) / NS;

   logic [DW-1:0]        data_q [NS];
   logic [DW-1:0]        data_d [NS];
   logic [AW-1:0]        amt_q  [NS];
   logic [AW-1:0]        amt_d  [NS];
   logic [2:0]           op_q   [NS];
   logic [2:0]           op_d   [NS];
   logic [TAG_WIDTH-1:0] tag_q  [NS];
   logic [TAG_WIDTH-1:0] tag_d  [NS];
   logic                 ill_q  [NS];
   logic                 ill_d  [NS];
   logic                 vld_q  [NS];
   logic                 vld_d  [NS];

   logic [DW-1:0]        src_data [NS];
   logic [AW-1:0]        src_amt  [NS];
   logic [2:0]           src_op   [NS];
   logic [TAG_WIDTH-1:0] src_tag  [NS];
   logic                 src_ill  [NS];
   logic                 src_vld  [NS];
   logic [DW-1:0]        shifted  [NS];

   logic adv;

   // One mux level. Shifting a double-width word gives the fill for free:
   // the extra half holds zeros, sign copies, or the word itself (rotate).
   function automatic logic [DW-1:0] shift_level(
      input logic [DW-1:0] d,
      input logic [2:0]    op,
      input int            sh
   );
      logic [2*DW-1:0] ext;
      logic [DW-1:0]   fill;
      logic            left;
      logic            rot;
      left = (op == 3'd0) || (op == 3'd3);
      rot  = (op == 3'd3) || (op == 3'd4);
      if (rot)
         fill = d;
      else if (op == 3'd2)
         fill = {DW{d[DW-1]}};
      else
         fill = '0;
      if (left) begin
         ext = {d, fill} << sh;
         shift_level = ext[2*DW-1:DW];
      end else begin
         ext = {fill, d} >> sh;
         shift_level = ext[DW-1:0];
      end
   endfunction

   // Single global enable: the whole pipe moves or the whole pipe holds.
   assign adv        = !vld_q[NS-1] || out_ready_i;
   assign in_ready_o = adv;

   always_comb begin
      // Illegal ops enter as zero data so every level yields zero.
      src_data[0] = (op_i > 3'd4) ? '0 : data_i;
      src_amt[0]  = amt_i;
      src_op[0]   = op_i;
      src_tag[0]  = tag_i;
      src_ill[0]  = (op_i > 3'd4);
      src_vld[0]  = in_valid_i;
      for (int s = 1; s < NS; s++) begin
         src_data[s] = data_q[s-1];
         src_amt[s]  = amt_q[s-1];
         src_op[s]   = op_q[s-1];
         src_tag[s]  = tag_q[s-1];
         src_ill[s]  = ill_q[s-1];
         src_vld[s]  = vld_q[s-1];
      end
      for (int s = 0; s < NS; s++) begin
         shifted[s] = src_data[s];
         for (int j = 0; j < AW; j++) begin
            if ((j / LPS) == s && src_amt[s][j])
               shifted[s] = shift_level(shifted[s], src_op[s], 1 << j);
         end
         data_d[s] = adv ? shifted[s] : data_q[s];
         amt_d[s]  = adv ? src_amt[s] : amt_q[s];
         op_d[s]   = adv ? src_op[s]  : op_q[s];
         tag_d[s]  = adv ? src_tag[s] : tag_q[s];
         ill_d[s]  = adv ? src_ill[s] : ill_q[s];
         vld_d[s]  = adv ? src_vld[s] : vld_q[s];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < NS; s++) begin
            data_q[s] <= '0;
            amt_q[s]  <= '0;
            op_q[s]   <= '0;
            tag_q[s]  <= '0;
            ill_q[s]  <= 1'b0;
            vld_q[s]  <= 1'b0;
         end
      end else begin
         for (int s = 0; s < NS; s++) begin
            data_q[s] <= data_d[s];
            amt_q[s]  <= amt_d[s];
            op_q[s]   <= op_d[s];
            tag_q[s]  <= tag_d[s];
            ill_q[s]  <= ill_d[s];
            vld_q[s]  <= vld_d[s];
         end
      end
   end

   assign out_valid_o = vld_q[NS-1];
   assign result_o    = data_q[NS-1];
   assign tag_o       = tag_q[NS-1];
   assign illegal_o   = ill_q[NS-1];

endmodule

// File: tb/tb_alu_shift_pipe.sv
// tb_alu_shift_pipe: directed vectors on the 32/2 config plus
// randomized scoreboard runs on 16/1, 16/3 and 64/5.
module tb_alu_shift_pipe;

   logic clk = 1'b0;
   logic rst_m = 1'b1;
   logic rst_rnd = 1'b1;
   int   err = 0;
   int   chk = 0;
   int   done = 0;

   always #5 clk = ~clk;

   logic        iv, ir, ov, ordy, ill;
   logic [2:0]  op;
   logic [31:0] d, res;
   logic [4:0]  amt, tag, to;

   alu_shift_pipe #(.DATA_WIDTH(32), .NUM_STAGES(2), .TAG_WIDTH(5)) dut (
      .clk_i(clk), .rst_i(rst_m),
      .in_valid_i(iv), .in_ready_o(ir),
      .op_i(op), .data_i(d), .amt_i(amt), .tag_i(tag),
      .out_valid_o(ov), .out_ready_i(ordy),
      .result_o(res), .tag_o(to), .illegal_o(ill)
   );

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      chk++;
      if (got !== exp) begin
         err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] d;
      logic [4:0]  a;
      logic [4:0]  t;
      logic [31:0] r;
      logic        il;
   } vec_t;

   // ---------------- randomized scoreboard runs ----------------
   for (genvar g = 0; g < 3; g++) begin : g_rnd
      localparam int W  = (g == 2) ? 64 : 16;
      localparam int NS = (g == 0) ? 1 : ((g == 1) ? 3 : 5);
      localparam int AW = $clog2(W);

      logic          riv, rir, rov, rordy, rill;
      logic [2:0]    rop;
      logic [W-1:0]  rd, rres;
      logic [AW-1:0] ra;
      logic [4:0]    rtg, rto;

      alu_shift_pipe #(.DATA_WIDTH(W), .NUM_STAGES(NS), .TAG_WIDTH(5)) u_dut (
         .clk_i(clk), .rst_i(rst_rnd),
         .in_valid_i(riv), .in_ready_o(rir),
         .op_i(rop), .data_i(rd), .amt_i(ra), .tag_i(rtg),
         .out_valid_o(rov), .out_ready_i(rordy),
         .result_o(rres), .tag_o(rto), .illegal_o(rill)
      );

      typedef struct {
         logic [W-1:0] r;
         logic [4:0]   t;
         logic         il;
         int           cyc;
         int           st;
      } exp_t;

      exp_t q[$];

      function automatic logic [W-1:0] model_sh(input logic [2:0] o, input logic [W-1:0] x, input int n);
         logic [W-1:0] y;
         case (o)
            3'd0: y = x << n;
            3'd1: y = x >> n;
            3'd2: y = W'($signed(x) >>> n);
            3'd3: y = (x << n) | (x >> (W - n));
            3'd4: y = (x >> n) | (x << (W - n));
            default: y = '0;
         endcase
         return y;
      endfunction

      task automatic pop_chk(input int cyc, input int st);
         exp_t e;
         int   want;
         chk++;
         if (q.size() == 0) begin
            err++;
            $display("FAIL rnd%0d_spurious: output with empty scoreboard at cycle %0d tag=%0d", g, cyc, rto);
         end else begin
            e = q.pop_front();
            want = e.cyc + NS + (st - e.st);
            if (rres !== e.r || rto !== e.t || rill !== e.il || cyc != want) begin
               err++;
               $display("FAIL rnd%0d_result: got r=%h tag=%0d ill=%b cyc=%0d, expected r=%h tag=%0d ill=%b cyc=%0d",
                        g, rres, rto, rill, cyc, e.r, e.t, e.il, want);
            end
         end
      endtask

      initial begin
         int   cyc;
         int   st;
         int   acc;
         exp_t e;
         cyc = 0; st = 0; acc = 0;
         riv = 1'b0; rordy = 1'b0; rop = '0; rd = '0; ra = '0; rtg = '0;
         wait (rst_rnd == 1'b0);
         while (acc < 1000 && cyc < 20000) begin
            @(posedge clk); #1;
            riv   = ($urandom % 10) < 7;
            rordy = ($urandom % 10) < 7;
            rop   = (($urandom % 16) == 0) ? 3'(5 + $urandom % 3) : 3'($urandom % 5);
            rd    = W'({$urandom(), $urandom()});
            ra    = AW'($urandom());
            rtg   = 5'($urandom());
            @(negedge clk);
            if (rov && rordy) pop_chk(cyc, st);
            if (riv && rir) begin
               e.r   = model_sh(rop, rd, int'(ra));
               e.t   = rtg;
               e.il  = (rop > 3'd4);
               e.cyc = cyc;
               e.st  = st;
               q.push_back(e);
               acc++;
            end
            if (rov && !rordy) st++;
            cyc++;
         end
         for (int k = 0; k < NS + 4; k++) begin
            @(posedge clk); #1;
            riv = 1'b0;
            rordy = 1'b1;
            @(negedge clk);
            if (rov && rordy) pop_chk(cyc, st);
            cyc++;
         end
         chk++;
         if (q.size() != 0 || acc < 1000) begin
            err++;
            $display("FAIL rnd%0d_drain: left=%0d accepted=%0d required left=0 accepted=1000", g, q.size(), acc);
         end
         done++;
      end
   end

   // ---------------- directed tests ----------------
   vec_t tbl[14];
   logic [4:0]  rx_tag [8];
   logic [31:0] rx_res [8];

   initial begin
      int          sent;
      int          got_n;
      logic        saw_block;
      logic        held_v;
      logic [31:0] held_r;
      logic [4:0]  held_t;
      logic        stale;

      tbl[0]  = '{3'd0, 32'h8000_00F1, 5'd4,  5'd0,  32'h0000_0F10, 1'b0};
      tbl[1]  = '{3'd1, 32'h8000_00F1, 5'd4,  5'd1,  32'h0800_000F, 1'b0};
      tbl[2]  = '{3'd2, 32'h8000_00F1, 5'd4,  5'd2,  32'hF800_000F, 1'b0};
      tbl[3]  = '{3'd3, 32'h8000_00F1, 5'd4,  5'd3,  32'h0000_0F18, 1'b0};
      tbl[4]  = '{3'd4, 32'h8000_00F1, 5'd4,  5'd4,  32'h1800_000F, 1'b0};
      tbl[5]  = '{3'd0, 32'hDEAD_BEEF, 5'd0,  5'd5,  32'hDEAD_BEEF, 1'b0};
      tbl[6]  = '{3'd1, 32'hDEAD_BEEF, 5'd0,  5'd6,  32'hDEAD_BEEF, 1'b0};
      tbl[7]  = '{3'd2, 32'hDEAD_BEEF, 5'd0,  5'd7,  32'hDEAD_BEEF, 1'b0};
      tbl[8]  = '{3'd3, 32'hDEAD_BEEF, 5'd0,  5'd8,  32'hDEAD_BEEF, 1'b0};
      tbl[9]  = '{3'd4, 32'hDEAD_BEEF, 5'd0,  5'd10, 32'hDEAD_BEEF, 1'b0};
      tbl[10] = '{3'd2, 32'hDEAD_BEEF, 5'd31, 5'd11, 32'hFFFF_FFFF, 1'b0};
      tbl[11] = '{3'd3, 32'hDEAD_BEEF, 5'd31, 5'd12, 32'hEF56_DF77, 1'b0};
      tbl[12] = '{3'd6, 32'hDEAD_BEEF, 5'd3,  5'd9,  32'h0000_0000, 1'b1};
      tbl[13] = '{3'd0, 32'h0000_0003, 5'd1,  5'd13, 32'h0000_0006, 1'b0};

      iv = 1'b0; ordy = 1'b1; op = '0; d = '0; amt = '0; tag = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_m = 1'b0;
      rst_rnd = 1'b0;

      @(negedge clk);
      check("rst_out_valid", 64'(ov), 64'd0);
      check("rst_result", 64'(res), 64'd0);
      check("rst_tag", 64'(to), 64'd0);
      check("rst_illegal", 64'(ill), 64'd0);
      check("rst_in_ready", 64'(ir), 64'd1);

      // table: back-to-back stream, each result due two cycles later
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         ordy = 1'b1;
         if (i < 14) begin
            iv = 1'b1; op = tbl[i].op; d = tbl[i].d;
            amt = tbl[i].a; tag = tbl[i].t;
         end else begin
            iv = 1'b0;
         end
         @(negedge clk);
         if (i >= 2) begin
            check($sformatf("vec%0d_valid", i-2), 64'(ov), 64'd1);
            check($sformatf("vec%0d_result", i-2), 64'(res), 64'(tbl[i-2].r));
            check($sformatf("vec%0d_tag", i-2), 64'(to), 64'(tbl[i-2].t));
            check($sformatf("vec%0d_illegal", i-2), 64'(ill), 64'(tbl[i-2].il));
         end else begin
            check($sformatf("early_valid%0d", i), 64'(ov), 64'd0);
         end
      end

      // backpressure: tags 1..4, consumer stalls in cycles 3..7
      sent = 0; got_n = 0; saw_block = 1'b0; held_v = 1'b0;
      held_r = '0; held_t = '0;
      for (int k = 0; k < 14; k++) begin
         @(posedge clk); #1;
         iv = (sent < 4);
         tag = 5'(sent + 1); op = 3'd0; d = 32'(sent + 1); amt = 5'd1;
         ordy = !(k >= 3 && k <= 7);
         @(negedge clk);
         if (ov && !ordy) begin
            if (held_v) begin
               check($sformatf("bp_hold_res_c%0d", k), 64'(res), 64'(held_r));
               check($sformatf("bp_hold_tag_c%0d", k), 64'(to), 64'(held_t));
            end
            held_v = 1'b1; held_r = res; held_t = to;
         end else begin
            held_v = 1'b0;
         end
         if (iv && !ir) saw_block = 1'b1;
         if (ov && ordy && got_n < 8) begin
            rx_tag[got_n] = to;
            rx_res[got_n] = res;
            got_n++;
         end
         if (iv && ir) sent++;
      end
      iv = 1'b0;
      check("bp_in_ready_drop", 64'(saw_block), 64'd1);
      check("bp_count", 64'(got_n), 64'd4);
      for (int i = 0; i < 4 && i < got_n; i++) begin
         check($sformatf("bp_order_tag%0d", i), 64'(rx_tag[i]), 64'(i + 1));
         check($sformatf("bp_order_res%0d", i), 64'(rx_res[i]), 64'(2 * (i + 1)));
      end

      // reset with two requests in flight
      @(posedge clk); #1;
      iv = 1'b1; tag = 5'd5; op = 3'd0; d = 32'h1; amt = 5'd0; ordy = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      tag = 5'd6;
      @(negedge clk);
      @(posedge clk); #1;
      iv = 1'b0; rst_m = 1'b1; ordy = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
      rst_m = 1'b0; ordy = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", 64'(ov), 64'd0);
      check("midrst_in_ready", 64'(ir), 64'd1);
      check("midrst_result", 64'(res), 64'd0);
      check("midrst_tag", 64'(to), 64'd0);
      stale = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (ov) stale = 1'b1;
      end
      check("midrst_no_stale", 64'(stale), 64'd0);

      for (int w = 0; w < 30000 && done < 3; w++) @(posedge clk);
      chk++;
      if (done < 3) begin
         err++;
         $display("FAIL rnd_timeout: finished runs %0d required 3", done);
      end

      $display("Result: errors=%0d of %0d checks", err, chk);
      $finish;
   end

endmodule
